data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
Memory-side responder for the controlpath load/store protocol. It accepts ld/st requests, holds wait_data high while an access is in flight, and returns load data tagged with its destination register. Accesses that are out of range, misaligned or malformed are reported on data_segv. It sits between the controlpath/datapath and a private synchronous data RAM.

Parameters:
DATA_WIDTH, 32, width of load/store data.
ADDR_WIDTH, 32, width of the byte address.
MEM_WORDS, 1024, number of DATA_WIDTH words in the RAM; must be a power of two.
LATENCY, 2, cycles spent in BUSY before completion; must be at least 1.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
ld  input  1  load request; held high by the requester until it sees wait_data low.
st  input  1  store request; same holding rule as ld.
addr  input  ADDR_WIDTH  byte address of the access.
store_data  input  DATA_WIDTH  store payload.
reg_addr  input  4  destination register of a load; captured with the request.
wait_data  output  1  access in flight; requester stalls while this is high.
data_segv  output  1  one-cycle pulse reporting an access fault.
load_data  output  DATA_WIDTH  value of the last completed load.
load_valid  output  1  one-cycle pulse: load_data and load_dest are valid.
load_dest  output  4  captured reg_addr of the completed load.

Behaviour:
- Reset values (when reset is high):
  - state = IDLE.
  - wait_data, data_segv, load_valid = 0.
  - load_data = 0, load_dest = 0.
  - Latency counter = 0.
  - RAM contents are not reset.
- A reset that arrives mid-access aborts the access. No RAM write occurs on that cycle.
- States: IDLE, BUSY, DONE, FAULT.
- IDLE, with req = ld | st:
  - wait_data = req, driven combinationally, so the requester never sees a gap.
  - On req, capture addr, store_data, reg_addr and the op type.
  - Fault check on the captured request; any one of these is a fault:
    - ld & st both high;
    - addr[1:0] != 0;
    - word index addr >> 2 >= MEM_WORDS.
  - Fault -> go to FAULT. Otherwise -> go to BUSY with counter = LATENCY-1.
- BUSY:
  - wait_data = 1.
  - The counter decrements each cycle.
  - When the counter is 0:
    - a store writes the RAM;
    - a load issues its RAM read;
    - go to DONE.
- DONE, one cycle:
  - wait_data = 0.
  - For a store: no pulse.
  - For a load: load_valid = 1; load_data and load_dest are updated on entry to DONE and are valid in this cycle.
  - Requests are ignored this cycle; the requester drops ld/st here.
  - Go to IDLE.
- FAULT, one cycle:
  - wait_data = 0, data_segv = 1.
  - No RAM write; load_data is unchanged.
  - Go to IDLE.
- Total latency for a valid access: request cycle + LATENCY BUSY cycles, then the DONE cycle.
  - With LATENCY = 2, a load asserted at cycle 0 gives load_valid at cycle 3.
- load_data holds its value until the next completed load.
- The RAM read is synchronous with 1-cycle latency, and that cycle is absorbed by the final BUSY cycle.
- Address, data and tag are latched in IDLE. Input changes during BUSY are ignored.
- The word index uses addr bits [log2(MEM_WORDS)+1:2]. The range check uses the full ADDR_WIDTH, so there is no wrap-around aliasing.
- A request still held high in the cycle after DONE is accepted as a new request. The requester must therefore drop ld/st in DONE.

Decomposition:
- Shared package mem_pkg:
  - state encoding (IDLE, BUSY, DONE, FAULT);
  - op type encoding (NONE, LOAD, STORE);
  - the fault-check helper function.
- One sub-module, data_ram: single-port synchronous RAM, DATA_WIDTH x MEM_WORDS, with write enable and registered read data.

Test Plan:
- Store then load:
  - st addr=0x10, store_data=0xDEADBEEF -> wait_data high 3 cycles, then low; no data_segv.
  - Then ld addr=0x10, reg_addr=5 -> load_valid at cycle 3 with load_data=0xDEADBEEF, load_dest=5.
- Out of range: ld addr=4*MEM_WORDS=0x1000 -> data_segv pulse 1 cycle after the request; wait_data low that cycle; load_valid stays 0; load_data unchanged.
- Misaligned: st addr=0x13 -> data_segv pulse; a following ld at 0x10 still returns the previous value.
- Simultaneous ld=st=1 at addr 0x20 -> data_segv pulse; RAM[8] unchanged.
- Reset mid-access:
  - Assert reset during BUSY of st addr=0x30, data=0x1234 -> all outputs 0 next cycle.
  - A later ld at 0x30 does not return 0x1234; the location holds its prior preloaded value.
- Back-to-back loads: requester re-asserts ld immediately after DONE at addr 0x0, then 0x4 -> each gets its own wait window and a correctly tagged load_valid; no request is lost or duplicated.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared types and the access fault rule for the data memory responder.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DONE  = 2'd2,
      FAULT = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      NONE  = 2'd0,
      LOAD  = 2'd1,
      STORE = 2'd2
   } op_t;

   // Range check uses the full address so high bits never alias into the RAM.
   function automatic logic access_fault(
      input logic        ld,
      input logic        st,
      input logic [63:0] addr,
      input logic [63:0] mem_words
   );
      logic f;
      f = 1'b0;
      if (ld && st) begin
         f = 1'b1;
      end else if (addr[1:0] != 2'b00) begin
         f = 1'b1;
      end else if ((addr >> 2) >= mem_words) begin
         f = 1'b1;
      end else begin
         f = 1'b0;
      end
      return f;
   endfunction

endpackage

// File: rtl/data_mem_responder_ram.sv
// Single-port synchronous RAM with registered read data (read-before-write).
module data_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_WORDS  = 1024,
   parameter int IDX_WIDTH  = $clog2(MEM_WORDS)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [IDX_WIDTH-1:0]  addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: latches a request, waits LATENCY cycles, then completes
// or reports a fault.
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int MEM_WORDS  = 1024,
   parameter int LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ld,
   input  logic                  st,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] store_data,
   input  logic [3:0]            reg_addr,
   output logic                  wait_data,
   output logic                  data_segv,
   output logic [DATA_WIDTH-1:0] load_data,
   output logic                  load_valid,
   output logic [3:0]            load_dest
);

   localparam int IW = $clog2(MEM_WORDS);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   state_t                state;
   op_t                   op;
   logic [IW-1:0]         idx;
   logic [DATA_WIDTH-1:0] wdata;
   logic [3:0]            tag;
   logic [CW-1:0]         cnt;

   logic                  req;
   logic                  fault;
   logic                  ram_we;
   logic [IW-1:0]         ram_addr;
   logic [DATA_WIDTH-1:0] ram_rdata;

   assign req   = ld | st;
   assign fault = access_fault(ld, st, 64'(addr), 64'(MEM_WORDS));

   // In IDLE the RAM already reads the incoming address, so the registered
   // read data is ready by the last BUSY cycle even when LATENCY is 1.
   always_comb begin
      ram_addr = idx;
      if (state == IDLE) begin
         ram_addr = addr[IW+1:2];
      end else begin
         ram_addr = idx;
      end
   end

   assign ram_we = (state == BUSY) && (cnt == '0) && (op == STORE) && !reset;

   always_comb begin
      wait_data = 1'b0;
      case (state)
         IDLE:    wait_data = req & ~reset;
         BUSY:    wait_data = ~reset;
         default: wait_data = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         op         <= NONE;
         idx        <= '0;
         wdata      <= '0;
         tag        <= 4'd0;
         cnt        <= '0;
         data_segv  <= 1'b0;
         load_valid <= 1'b0;
         load_data  <= '0;
         load_dest  <= 4'd0;
      end else begin
         data_segv  <= 1'b0;
         load_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  op    <= st ? STORE : LOAD;
                  idx   <= addr[IW+1:2];
                  wdata <= store_data;
                  tag   <= reg_addr;
                  if (fault) begin
                     state     <= FAULT;
                     data_segv <= 1'b1;
                  end else begin
                     state <= BUSY;
                     cnt   <= CW'(LATENCY - 1);
                  end
               end
            end
            BUSY: begin
               if (cnt == '0) begin
                  state <= DONE;
                  if (op == LOAD) begin
                     load_valid <= 1'b1;
                     load_data  <= ram_rdata;
                     load_dest  <= tag;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            DONE:    state <= IDLE;
            FAULT:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   data_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .MEM_WORDS (MEM_WORDS),
      .IDX_WIDTH (IW)
   ) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .addr (ram_addr),
      .wdata(wdata),
      .rdata(ram_rdata)
   );

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a cycle-timed access model.
module tb_data_mem_responder;

   localparam int LAT = 2;
   localparam int MW  = 1024;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ld = 1'b0;
   logic        st = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] store_data = 32'd0;
   logic [3:0]  reg_addr = 4'd0;
   logic        wait_data;
   logic        data_segv;
   logic [31:0] load_data;
   logic        load_valid;
   logic [3:0]  load_dest;

   data_mem_responder #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_WORDS(MW), .LATENCY(LAT)
   ) dut (
      .clk(clk), .reset(reset), .ld(ld), .st(st), .addr(addr),
      .store_data(store_data), .reg_addr(reg_addr), .wait_data(wait_data),
      .data_segv(data_segv), .load_data(load_data), .load_valid(load_valid),
      .load_dest(load_dest)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_fail = 0;
   int cyc = 0;
   int req_cyc = 0;
   int lv_cycle = -1;
   int sv_cycle = -1;
   int wait_cnt = 0;
   int n_lv = 0;

   // model: memory image plus the one access in flight
   logic [31:0] mem_m [MW];
   bit          known [MW];
   bit          m_active = 1'b0;
   int          m_start = 0;
   bit          m_fault = 1'b0;
   bit          m_load = 1'b0;
   int          m_idx = 0;
   logic [31:0] m_data = 32'd0;
   logic [3:0]  m_tag = 4'd0;
   logic [31:0] e_data = 32'd0;
   logic [3:0]  e_dest = 4'd0;
   bit          e_known = 1'b1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_step();
      logic e_wait, e_segv, e_valid;
      int k;
      e_wait = 1'b0; e_segv = 1'b0; e_valid = 1'b0; k = 0;
      if (reset) begin
         m_active = 1'b0;
         e_data = 32'd0; e_dest = 4'd0; e_known = 1'b1;
      end else begin
         if (!m_active) begin
            e_wait = ld | st;
         end else begin
            k = cyc - m_start;
            if (m_fault) begin
               e_segv = (k == 1);
            end else if (k <= LAT) begin
               e_wait = 1'b1;
            end else begin
               e_valid = m_load;
               if (m_load) begin
                  e_data = mem_m[m_idx]; e_known = known[m_idx]; e_dest = m_tag;
               end
            end
         end
         chk("wait_data", 64'(wait_data), 64'(e_wait));
         chk("data_segv", 64'(data_segv), 64'(e_segv));
         chk("load_valid", 64'(load_valid), 64'(e_valid));
         if (e_known) chk("load_data", 64'(load_data), 64'(e_data));
         chk("load_dest", 64'(load_dest), 64'(e_dest));
         if (!m_active) begin
            if (ld | st) begin
               m_active = 1'b1; m_start = cyc; m_load = ld;
               m_fault = (ld && st) || (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(MW));
               m_idx = int'(addr[11:2]); m_data = store_data; m_tag = reg_addr;
            end
         end else if (m_fault) begin
            m_active = 1'b0;
         end else if (k == LAT) begin
            if (!m_load) begin
               mem_m[m_idx] = m_data; known[m_idx] = 1'b1;
            end
         end else if (k == LAT + 1) begin
            m_active = 1'b0;
         end
      end
   endtask

   task automatic tick();
      logic w;
      @(negedge clk);
      model_step();
      if (load_valid === 1'b1) begin lv_cycle = cyc; n_lv++; end
      if (data_segv === 1'b1) sv_cycle = cyc;
      if (wait_data === 1'b1) wait_cnt++;
      w = wait_data;
      @(posedge clk); #1;
      cyc++;
      if ((ld | st) && (w !== 1'b1)) begin
         ld = 1'b0; st = 1'b0;
      end else if (ld | st) begin
         addr = $urandom; store_data = $urandom; reg_addr = 4'($urandom);
      end
   endtask

   task automatic request(input logic l, input logic s, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] t);
      ld = l; st = s; addr = a; store_data = d; reg_addr = t; req_cyc = cyc;
      for (int i = 0; i < 12 && (ld | st); i++) tick();
      if (ld | st) begin
         n_vec++; n_fail++;
         $display("FAIL request_timeout at cycle %0d: got wait_data stuck expected release", cyc);
         ld = 1'b0; st = 1'b0;
      end
   endtask

   initial begin
      for (int i = 0; i < MW; i++) known[i] = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      chk("rst_wait", 64'(wait_data), 64'd0);
      chk("rst_segv", 64'(data_segv), 64'd0);
      chk("rst_valid", 64'(load_valid), 64'd0);
      chk("rst_data", 64'(load_data), 64'd0);
      chk("rst_dest", 64'(load_dest), 64'd0);

      for (int w = 0; w < 32; w++) request(1'b0, 1'b1, 32'(w * 4), $urandom, 4'd0);
      request(1'b0, 1'b1, 32'h20, 32'h0BAD0020, 4'd0);
      request(1'b0, 1'b1, 32'h30, 32'hCAFE0030, 4'd0);

      wait_cnt = 0; sv_cycle = -1;
      request(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'd0);
      chk("st_wait_cycles", 64'(wait_cnt), 64'd3);
      chk("st_no_segv", 64'(sv_cycle), 64'(-1));
      request(1'b1, 1'b0, 32'h10, 32'd0, 4'd5);
      chk("ld_latency", 64'(lv_cycle - req_cyc), 64'd3);
      chk("ld_data", 64'(load_data), 64'hDEADBEEF);
      chk("ld_dest", 64'(load_dest), 64'd5);

      lv_cycle = -1; sv_cycle = -1;
      request(1'b1, 1'b0, 32'h1000, 32'd0, 4'd3);
      chk("oor_segv_delay", 64'(sv_cycle - req_cyc), 64'd1);
      chk("oor_no_valid", 64'(lv_cycle), 64'(-1));
      chk("oor_data_kept", 64'(load_data), 64'hDEADBEEF);

      sv_cycle = -1;
      request(1'b0, 1'b1, 32'h13, 32'h55555555, 4'd0);
      chk("mis_segv_delay", 64'(sv_cycle - req_cyc), 64'd1);
      request(1'b1, 1'b0, 32'h10, 32'd0, 4'd6);
      chk("mis_ld_data", 64'(load_data), 64'hDEADBEEF);

      sv_cycle = -1;
      request(1'b1, 1'b1, 32'h20, 32'h77777777, 4'd0);
      chk("both_segv_delay", 64'(sv_cycle - req_cyc), 64'd1);
      request(1'b1, 1'b0, 32'h20, 32'd0, 4'd7);
      chk("both_ram_kept", 64'(load_data), 64'h0BAD0020);

      ld = 1'b0; st = 1'b1; addr = 32'h30; store_data = 32'h1234; reg_addr = 4'd0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst_wait", 64'(wait_data), 64'd0);
      chk("midrst_segv", 64'(data_segv), 64'd0);
      chk("midrst_valid", 64'(load_valid), 64'd0);
      chk("midrst_data", 64'(load_data), 64'd0);
      chk("midrst_dest", 64'(load_dest), 64'd0);
      tick();
      request(1'b1, 1'b0, 32'h30, 32'd0, 4'd9);
      chk("midrst_ram_kept", 64'(load_data), 64'hCAFE0030);

      n_lv = 0;
      request(1'b1, 1'b0, 32'h0, 32'd0, 4'd1);
      request(1'b1, 1'b0, 32'h4, 32'd0, 4'd2);
      tick();
      chk("b2b_pulses", 64'(n_lv), 64'd2);
      chk("b2b_last_dest", 64'(load_dest), 64'd2);

      for (int n = 0; n < 250; n++) begin
         logic [31:0] a;
         logic        l, s;
         int          r;
         r = $urandom_range(0, 9);
         l = 1'($urandom); s = ~l;
         a = 32'($urandom_range(0, 31)) << 2;
         if (r == 6) a = a | 32'($urandom_range(1, 3));
         else if (r == 7) a = ($urandom & 32'hFFFF_FFFC) | 32'h1000;
         else if (r == 8) begin l = 1'b1; s = 1'b1; end
         else if (r == 9) a = 32'hFFFF_FFF0;
         request(l, s, a, $urandom, 4'($urandom));
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
